// File: rtl/spi_frame_sender_if.sv
// Frame handshake plus SPI pin bundle between a frame source and spi_frame_sender.
// The slave modport is the sender's view; the master modport is the frame source / pin model.
interface spi_frame_sender_if #(
  parameter int DATA_W = 16
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              cs;
  logic              sclk;
  logic              copi;
  logic              cipo;

  modport master (
    output tx_valid, tx_data, cipo,
    input  tx_ready, rx_data, rx_valid, busy, cs, sclk, copi
  );

  modport slave (
    input  tx_valid, tx_data, cipo,
    output tx_ready, rx_data, rx_valid, busy, cs, sclk, copi
  );
endinterface

// File: rtl/spi_frame_sender.sv
// SPI mode-0 initiator: sends DATA_W-bit frames MSB-first on copi while capturing cipo into rx_data.
// Accept-to-rx_valid latency is CS_SETUP+2*DATA_W*SCLK_HALF+CS_HOLD+1; tx_ready is high only in IDLE.
module spi_frame_sender #(
  parameter int DATA_W    = 16,
  parameter int SCLK_HALF = 2,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_IDLE   = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_frame_sender_if.slave bus
);

  localparam int PH_MAX0 = (SCLK_HALF > CS_SETUP) ? SCLK_HALF : CS_SETUP;
  localparam int PH_MAX1 = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int PH_MAX  = (PH_MAX0 > PH_MAX1) ? PH_MAX0 : PH_MAX1;
  localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(SCLK_HALF - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'((CS_IDLE > 0) ? CS_IDLE - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_FIRST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]  rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               copi_q, copi_d;
  logic               tx_ready_q, tx_ready_d;
  logic               busy_q, busy_d;
  logic               rx_valid_q, rx_valid_d;
  logic               ph_last;
  logic               accept;

  assign accept = bus.tx_valid && tx_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      copi_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      copi_q     <= copi_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + PH_W'(1);
    bit_d   = bit_q;
    ph_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        ph_d = '0;
        if (accept) begin
          state_d = SETUP;
          bit_d   = BIT_FIRST;
        end
      end
      SETUP: begin
        ph_last = (ph_q == SETUP_LAST);
        if (ph_last) begin
          state_d = HIGH;
          ph_d    = '0;
        end
      end
      HIGH: begin
        ph_last = (ph_q == HALF_LAST);
        if (ph_last) begin
          state_d = LOW;
          ph_d    = '0;
        end
      end
      LOW: begin
        ph_last = (ph_q == HALF_LAST);
        if (ph_last) begin
          ph_d = '0;
          if (bit_q != '0) begin
            state_d = HIGH;
            bit_d   = bit_q - BIT_W'(1);
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        ph_last = (ph_q == HOLD_LAST);
        if (ph_last) begin
          state_d = (CS_IDLE == 0) ? IDLE : GAP;
          ph_d    = '0;
        end
      end
      GAP: begin
        ph_last = (ph_q == GAP_LAST);
        if (ph_last) begin
          state_d = IDLE;
          ph_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
      end
    endcase
  end

  // Pin outputs follow the next state so every output is a flop yet lines up with its state.
  always_comb begin
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    copi_d     = copi_q;
    rx_valid_d = 1'b0;

    if (accept) begin
      tx_sr_d = bus.tx_data;
      copi_d  = bus.tx_data[DATA_W-1];
      rx_sr_d = '0;
    end

    // Leaving HIGH: sample cipo, and present the next bit as sclk falls.
    if (state_q == HIGH && ph_last) begin
      rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.cipo};
      if (bit_q != '0) begin
        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
        copi_d  = tx_sr_q[DATA_W-2];
      end
    end

    if (state_q == HOLD && ph_last) begin
      copi_d     = 1'b0;
      rx_data_d  = rx_sr_q;
      rx_valid_d = 1'b1;
    end

    cs_d       = !(state_d == SETUP || state_d == HIGH || state_d == LOW || state_d == HOLD);
    sclk_d     = (state_d == HIGH);
    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  assign bus.cs       = cs_q;
  assign bus.sclk     = sclk_q;
  assign bus.copi     = copi_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_frame_sender.sv
`timescale 1ns/1ps
// Bench for spi_frame_sender: default-timing instance plus a fast-timing instance, scoreboarded frames.
module tb_spi_frame_sender;
  localparam int DW     = 16;
  localparam int A_CSL  = 2 + 2 * DW * 2 + 2;
  localparam int A_IDLE = 2;
  localparam int B_CSL  = 1 + 2 * DW * 1 + 1;
  localparam int B_IDLE = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a = 1'b1;
  logic          rst_b = 1'b1;
  logic          tv [2];
  logic [DW-1:0] td [2];
  logic          cipo_mode = 1'b0;
  logic          cipo_drv = 1'b0;
  logic [DW-1:0] pat = '0;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  logic [DW-1:0] exp_tx_a [$];
  logic [DW-1:0] exp_rx_a [$];
  logic [DW-1:0] exp_tx_b [$];
  logic [DW-1:0] exp_rx_b [$];

  spi_frame_sender_if #(.DATA_W(DW)) a_if ();
  spi_frame_sender_if #(.DATA_W(DW)) b_if ();

  assign a_if.tx_valid = tv[0];
  assign a_if.tx_data  = td[0];
  assign a_if.cipo     = cipo_mode ? cipo_drv : a_if.copi;
  assign b_if.tx_valid = tv[1];
  assign b_if.tx_data  = td[1];
  assign b_if.cipo     = b_if.copi;

  spi_frame_sender #(.DATA_W(DW)) dut_a (
    .clk  (clk),
    .reset(rst_a),
    .bus  (a_if.slave)
  );

  spi_frame_sender #(.DATA_W(DW), .SCLK_HALF(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(0)) dut_b (
    .clk  (clk),
    .reset(rst_b),
    .bus  (b_if.slave)
  );

  logic [1:0]    rst_w, cs_w, sclk_w, copi_w, rdy_w, bsy_w, rxv_w, vld_w;
  logic [DW-1:0] rxd_w [2];
  assign rst_w    = {rst_b, rst_a};
  assign cs_w     = {b_if.cs, a_if.cs};
  assign sclk_w   = {b_if.sclk, a_if.sclk};
  assign copi_w   = {b_if.copi, a_if.copi};
  assign rdy_w    = {b_if.tx_ready, a_if.tx_ready};
  assign bsy_w    = {b_if.busy, a_if.busy};
  assign rxv_w    = {b_if.rx_valid, a_if.rx_valid};
  assign vld_w    = {tv[1], tv[0]};
  assign rxd_w[0] = a_if.rx_data;
  assign rxd_w[1] = b_if.rx_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Target model for cipo: presents the pattern MSB while cs is high, next bit after each sclk fall.
  int   pidx = DW - 1;
  logic pd_sclk = 1'b0;
  always @(negedge clk) begin
    if (a_if.cs) pidx = DW - 1;
    else if (pd_sclk && !a_if.sclk && pidx > 0) pidx--;
    cipo_drv = pat[pidx];
    pd_sclk  = a_if.sclk;
  end

  bit            act [2];
  bit            seen [2];
  int            acc_e [2];
  int            cs_low [2];
  int            rises [2];
  logic [DW-1:0] bits [2];
  int            vrb [2];
  int            vcp [2];
  int            cs_high [2];
  logic          p_cs [2];
  logic          p_sclk [2];
  logic          p_copi [2];
  logic          p_rxv [2];

  task automatic mon(input int d);
    int csl, gmin, sz;
    logic [DW-1:0] e;
    csl  = (d == 0) ? A_CSL : B_CSL;
    gmin = ((d == 0) ? A_IDLE : B_IDLE) + 1;
    if (rst_w[d]) begin
      act[d] = 0; seen[d] = 0; cs_high[d] = 0; vrb[d] = 0; vcp[d] = 0;
      p_cs[d] = 1'b1; p_sclk[d] = 1'b0; p_copi[d] = 1'b0; p_rxv[d] = 1'b0;
      if (d == 0) begin exp_tx_a.delete(); exp_rx_a.delete(); end
      else begin exp_tx_b.delete(); exp_rx_b.delete(); end
      return;
    end
    if (act[d]) begin
      if (!cs_w[d]) cs_low[d]++;
      if (!cs_w[d] && (rdy_w[d] || !bsy_w[d])) vrb[d]++;
      if (sclk_w[d] && !p_sclk[d]) begin
        rises[d]++;
        bits[d] = {bits[d][DW-2:0], copi_w[d]};
      end
    end
    if (copi_w[d] !== p_copi[d] && sclk_w[d]) vcp[d]++;
    if (!cs_w[d] && p_cs[d] && seen[d])
      chk("cs_high_gap", (cs_high[d] < gmin) ? cs_high[d] : gmin, gmin);
    if (act[d] && cs_w[d] && !p_cs[d]) begin
      chk("cs_low_cycles", cs_low[d], csl);
      chk("sclk_rise_count", rises[d], DW);
      sz = (d == 0) ? exp_tx_a.size() : exp_tx_b.size();
      chk("tx_expectation_available", sz > 0, 1);
      if (sz > 0) begin
        if (d == 0) e = exp_tx_a.pop_front();
        else e = exp_tx_b.pop_front();
        chk("copi_bits_on_sclk_rise", bits[d], e);
      end
      chk("ready_busy_violations_in_frame", vrb[d], 0);
      chk("copi_change_while_sclk_high", vcp[d], 0);
      chk("rx_valid_with_cs_rise", rxv_w[d], 1);
      act[d] = 0; seen[d] = 1; cs_high[d] = 0; vcp[d] = 0;
    end
    if (cs_w[d]) cs_high[d]++;
    if (rxv_w[d]) begin
      chk("rx_valid_single_cycle", p_rxv[d], 0);
      chk("accept_to_rx_valid_latency", cyc - acc_e[d] + 1, csl + 1);
      sz = (d == 0) ? exp_rx_a.size() : exp_rx_b.size();
      chk("rx_expectation_available", sz > 0, 1);
      if (sz > 0) begin
        if (d == 0) e = exp_rx_a.pop_front();
        else e = exp_rx_b.pop_front();
        chk("rx_data", rxd_w[d], e);
      end
    end
    if (vld_w[d] && rdy_w[d]) begin
      act[d] = 1; acc_e[d] = cyc + 1; cs_low[d] = 0; rises[d] = 0; bits[d] = '0; vrb[d] = 0;
    end
    p_cs[d] = cs_w[d]; p_sclk[d] = sclk_w[d]; p_copi[d] = copi_w[d]; p_rxv[d] = rxv_w[d];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic push_exp(input int d, input logic [DW-1:0] t, input logic [DW-1:0] r);
    if (d == 0) begin exp_tx_a.push_back(t); exp_rx_a.push_back(r); end
    else begin exp_tx_b.push_back(t); exp_rx_b.push_back(r); end
  endtask

  task automatic wait_acc(input int d, output int acc);
    bit got;
    got = 0;
    acc = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (rdy_w[d] && !rst_w[d]) begin acc = cyc + 1; got = 1; end
    end
    chk("accept_within_budget", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input int d);
    bit got;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (rxv_w[d]) got = 1;
    end
    chk("rx_valid_within_budget", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input int d, input logic [DW-1:0] w, input logic [DW-1:0] r, output int acc);
    push_exp(d, w, r);
    td[d] = w;
    tv[d] = 1'b1;
    wait_acc(d, acc);
    tv[d] = 1'b0;
    td[d] = DW'($urandom);
  endtask

  initial begin
    int            a1, a2, cnt;
    logic [DW-1:0] w;
    logic          ps;
    tv[0] = 1'b0; tv[1] = 1'b0; td[0] = '0; td[1] = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_cs", a_if.cs, 1);
    chk("reset_sclk", a_if.sclk, 0);
    chk("reset_copi", a_if.copi, 0);
    chk("reset_tx_ready", a_if.tx_ready, 1);
    chk("reset_busy", a_if.busy, 0);
    chk("reset_rx_valid", a_if.rx_valid, 0);
    chk("reset_rx_data", a_if.rx_data, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;

    // loopback of a known word
    cipo_mode = 1'b0;
    send(0, 16'h136F, 16'h136F, a1);
    wait_rx(0);

    // back-to-back with tx_valid held high
    push_exp(0, 16'h136F, 16'h136F);
    push_exp(0, 16'h20AA, 16'h20AA);
    td[0] = 16'h136F;
    tv[0] = 1'b1;
    wait_acc(0, a1);
    td[0] = 16'h20AA;
    wait_acc(0, a2);
    tv[0] = 1'b0;
    chk("back_to_back_accept_spacing", a2 - a1, A_CSL + 1 + A_IDLE);
    wait_rx(0);

    // tx_data changes right after accept must not leak into the frame
    push_exp(0, 16'h20AA, 16'h20AA);
    td[0] = 16'h20AA;
    tv[0] = 1'b1;
    wait_acc(0, a1);
    tv[0] = 1'b0;
    td[0] = 16'hFFFF;
    wait_rx(0);

    // receive from a target model, then cipo tied high
    cipo_mode = 1'b1;
    pat = 16'hA5A5;
    send(0, DW'($urandom), 16'hA5A5, a1);
    wait_rx(0);
    pat = 16'hFFFF;
    send(0, DW'($urandom), 16'hFFFF, a1);
    wait_rx(0);

    // asynchronous reset after the 7th sclk rise
    cipo_mode = 1'b0;
    push_exp(0, 16'h5A3C, 16'h5A3C);
    td[0] = 16'h5A3C;
    tv[0] = 1'b1;
    wait_acc(0, a1);
    tv[0] = 1'b0;
    cnt = 0;
    ps  = a_if.sclk;
    for (int i = 0; i < 400 && cnt < 7; i++) begin
      @(negedge clk);
      if (a_if.sclk && !ps) cnt++;
      ps = a_if.sclk;
    end
    chk("seventh_sclk_rise_seen", cnt, 7);
    @(posedge clk); #2;
    rst_a = 1'b1;
    #1;
    chk("async_reset_cs", a_if.cs, 1);
    chk("async_reset_sclk", a_if.sclk, 0);
    chk("async_reset_copi", a_if.copi, 0);
    chk("async_reset_rx_valid", a_if.rx_valid, 0);
    chk("async_reset_busy", a_if.busy, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b0;
    chk("rx_data_cleared_by_reset", a_if.rx_data, 0);
    @(posedge clk); #1;
    send(0, 16'h20AA, 16'h20AA, a1);
    wait_rx(0);

    // randomized frames, loopback or target-model cipo
    for (int k = 0; k < 6; k++) begin
      cipo_mode = 1'($urandom_range(0, 1));
      pat = DW'($urandom);
      w   = DW'($urandom);
      send(0, w, cipo_mode ? pat : w, a1);
      wait_rx(0);
    end

    // fast-timing instance: loopback frames and back-to-back spacing
    for (int k = 0; k < 4; k++) begin
      w = DW'($urandom);
      send(1, w, w, a1);
      wait_rx(1);
    end
    push_exp(1, 16'h136F, 16'h136F);
    push_exp(1, 16'h20AA, 16'h20AA);
    td[1] = 16'h136F;
    tv[1] = 1'b1;
    wait_acc(1, a1);
    td[1] = 16'h20AA;
    wait_acc(1, a2);
    tv[1] = 1'b0;
    chk("fast_back_to_back_accept_spacing", a2 - a1, B_CSL + 1 + B_IDLE);
    wait_rx(1);

    repeat (4) @(posedge clk);
    #1;
    chk("a_rx_queue_drained", exp_rx_a.size(), 0);
    chk("b_rx_queue_drained", exp_rx_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got %0d checks, required the full sequence", n_chk);
    $fatal(1, "time limit reached");
  end

endmodule
